// File: rtl/systolic_pkg.sv
// Shared types and helpers for the weight-stationary systolic tile:
// FSM state encoding, derived widths and output saturation.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Wide enough for any partial sum plus bias before clamping.
  localparam int SAT_W = 64;

  function automatic int acc_bits(input int data_w, input int wt_w, input int n_in);
    return data_w + wt_w + $clog2(n_in);
  endfunction

  function automatic int pipe_latency(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v,
                                                     input int width);
    logic signed [SAT_W-1:0] hi_v;
    logic signed [SAT_W-1:0] lo_v;
    hi_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo_v = -(64'sd1 <<< (width - 1));
    if (v > hi_v) begin
      sat_to = hi_v;
    end else if (v < lo_v) begin
      sat_to = lo_v;
    end else begin
      sat_to = v;
    end
  endfunction

endpackage

// File: rtl/systolic_ws_pe.sv
// One weight-stationary MAC cell: holds a signed weight, forwards the
// activation to the right and adds a*w to the partial sum coming from above.
module systolic_ws_pe #(
  parameter int BitSize        = 8,
  parameter int Weight_BitSize = 4,
  parameter int AccBitSize     = 14
) (
  input  logic                      clk,
  input  logic                      res_n,
  input  logic                      en,
  input  logic                      w_ld,
  input  logic [Weight_BitSize-1:0] w_in,
  output logic [Weight_BitSize-1:0] w_out,
  input  logic [BitSize-1:0]        a_in,
  output logic [BitSize-1:0]        a_out,
  input  logic [AccBitSize-1:0]     ps_in,
  output logic [AccBitSize-1:0]     ps_out
);

  logic [Weight_BitSize-1:0]    w_r;
  logic [BitSize-1:0]           a_r;
  logic [AccBitSize-1:0]        ps_r;
  logic signed [AccBitSize-1:0] prod_s;

  // Both operands are sign-extended before the multiply so the product is exact.
  always_comb begin
    prod_s = AccBitSize'($signed(a_in)) * AccBitSize'($signed(w_r));
  end

  // Weight register, shifted only while weights are being loaded.
  always_ff @(posedge clk) begin
    if (res_n) begin
      w_r <= {Weight_BitSize{1'b0}};
    end else if (w_ld) begin
      w_r <= w_in;
    end else begin
      w_r <= w_r;
    end
  end

  // Activation forward and accumulate, frozen during a global stall.
  always_ff @(posedge clk) begin
    if (res_n) begin
      a_r  <= {BitSize{1'b0}};
      ps_r <= {AccBitSize{1'b0}};
    end else if (en) begin
      a_r  <= a_in;
      ps_r <= ps_in + prod_s;
    end else begin
      a_r  <= a_r;
      ps_r <= ps_r;
    end
  end

  assign w_out  = w_r;
  assign a_out  = a_r;
  assign ps_out = ps_r;

endmodule

// File: rtl/systolic_tile_ws.sv
// Weight-stationary systolic tile computing Y = sat(X*W + bias) one aligned
// row per cycle, with internal skew/deskew, weight loading and backpressure.
module systolic_tile_ws
  import systolic_pkg::*;
#(
  parameter int BitSize        = 8,
  parameter int Weight_BitSize = 4,
  parameter int NumOfInputs    = 4,
  parameter int NumOfNerves    = 4
) (
  input  logic                                clk,
  input  logic                                res_n,
  input  logic                                w_valid,
  output logic                                w_ready,
  input  logic [NumOfNerves*Weight_BitSize-1:0] w_data,
  input  logic [NumOfNerves*BitSize-1:0]      bias,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NumOfInputs*BitSize-1:0]      in_data,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NumOfNerves*BitSize-1:0]      out_data,
  output logic                                out_last,
  output logic                                busy
);

  localparam int AccBitSize = acc_bits(BitSize, Weight_BitSize, NumOfInputs);
  localparam int LAT        = pipe_latency(NumOfInputs, NumOfNerves);
  localparam int CNT_W      = (NumOfInputs > 1) ? $clog2(NumOfInputs) : 1;
  localparam bit ONE_ROW    = (NumOfInputs == 1);

  state_e             state_r, state_s;
  logic               loaded_r, loaded_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               w_ready_s, in_ready_s;
  logic               adv_s, in_fire_s, w_ld_s, pipe_empty_s;
  logic               pe_edge_unused_s;

  logic [1:0]                      vp_r [LAT-1];
  logic                            out_valid_r, out_last_r;
  logic [NumOfNerves*BitSize-1:0]  out_data_r, out_next_s;

  logic [BitSize-1:0]        a_h  [NumOfInputs][NumOfNerves+1];
  logic [AccBitSize-1:0]     ps_h [NumOfInputs+1][NumOfNerves];
  logic [Weight_BitSize-1:0] w_h  [NumOfInputs+1][NumOfNerves];
  logic [AccBitSize-1:0]     ds_h [NumOfNerves];

  assign adv_s     = !(out_valid_r && !out_ready);
  assign in_fire_s = in_valid && in_ready_s;
  assign w_ld_s    = w_valid && w_ready_s;

  // Pipeline is empty when no valid token sits ahead of the output stage.
  always_comb begin
    pipe_empty_s = 1'b1;
    for (int k = 0; k < LAT - 1; k++) begin
      pipe_empty_s = pipe_empty_s & !vp_r[k][1];
    end
  end

  // Next-state and handshake logic; weights win over inputs in IDLE.
  always_comb begin
    state_s    = state_r;
    loaded_s   = loaded_r;
    cnt_s      = cnt_r;
    w_ready_s  = 1'b0;
    in_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        w_ready_s  = 1'b1;
        in_ready_s = loaded_r && !w_valid;
        if (w_valid) begin
          loaded_s = ONE_ROW;
          cnt_s    = CNT_W'(32'd1);
          state_s  = ONE_ROW ? IDLE : LOAD;
        end else if (loaded_r && in_valid) begin
          state_s = in_last ? DRAIN : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        w_ready_s = 1'b1;
        if (w_valid && (cnt_r == CNT_W'(NumOfInputs - 1))) begin
          loaded_s = 1'b1;
          cnt_s    = {CNT_W{1'b0}};
          state_s  = IDLE;
        end else if (w_valid) begin
          cnt_s = cnt_r + CNT_W'(32'd1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      RUN: begin
        in_ready_s = adv_s;
        if (in_valid && adv_s && in_last) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (pipe_empty_s && (!out_valid_r || out_ready)) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s  = IDLE;
        loaded_s = 1'b0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (res_n) begin
      state_r  <= IDLE;
      loaded_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      loaded_r <= loaded_s;
      cnt_r    <= cnt_s;
    end
  end

  genvar gi, gj;
  for (gi = 0; gi < NumOfInputs; gi++) begin : g_row
    logic [BitSize-1:0] row_in_s;
    assign row_in_s = in_fire_s ? in_data[gi*BitSize +: BitSize] : {BitSize{1'b0}};
    if (gi == 0) begin : g_noskew
      assign a_h[gi][0] = row_in_s;
    end else begin : g_skew
      logic [BitSize-1:0] dly_r [gi];
      // Input skew: row gi reaches its PE row gi cycles later.
      always_ff @(posedge clk) begin
        if (res_n) begin
          for (int k = 0; k < gi; k++) dly_r[k] <= {BitSize{1'b0}};
        end else if (adv_s) begin
          dly_r[0] <= row_in_s;
          for (int k = 1; k < gi; k++) dly_r[k] <= dly_r[k-1];
        end else begin
          for (int k = 0; k < gi; k++) dly_r[k] <= dly_r[k];
        end
      end
      assign a_h[gi][0] = dly_r[gi-1];
    end
    for (gj = 0; gj < NumOfNerves; gj++) begin : g_pe
      systolic_ws_pe #(
        .BitSize       (BitSize),
        .Weight_BitSize(Weight_BitSize),
        .AccBitSize    (AccBitSize)
      ) u_pe (
        .clk   (clk),
        .res_n (res_n),
        .en    (adv_s),
        .w_ld  (w_ld_s),
        .w_in  (w_h[gi+1][gj]),
        .w_out (w_h[gi][gj]),
        .a_in  (a_h[gi][gj]),
        .a_out (a_h[gi][gj+1]),
        .ps_in (ps_h[gi][gj]),
        .ps_out(ps_h[gi+1][gj])
      );
    end
  end

  // Weights enter at the bottom row and shift upward, so row k settles in PE row k.
  for (gj = 0; gj < NumOfNerves; gj++) begin : g_col
    assign ps_h[0][gj]           = {AccBitSize{1'b0}};
    assign w_h[NumOfInputs][gj]  = w_data[gj*Weight_BitSize +: Weight_BitSize];
    if (gj == NumOfNerves - 1) begin : g_nodeskew
      assign ds_h[gj] = ps_h[NumOfInputs][gj];
    end else begin : g_deskew
      localparam int D = NumOfNerves - 1 - gj;
      logic [AccBitSize-1:0] dly_r [D];
      // Output deskew: earlier columns wait for the last one.
      always_ff @(posedge clk) begin
        if (res_n) begin
          for (int k = 0; k < D; k++) dly_r[k] <= {AccBitSize{1'b0}};
        end else if (adv_s) begin
          dly_r[0] <= ps_h[NumOfInputs][gj];
          for (int k = 1; k < D; k++) dly_r[k] <= dly_r[k-1];
        end else begin
          for (int k = 0; k < D; k++) dly_r[k] <= dly_r[k];
        end
      end
      assign ds_h[gj] = dly_r[D-1];
    end
  end

  // Bias add and clamp to the signed output range.
  always_comb begin
    logic signed [SAT_W-1:0] sum_v;
    logic signed [SAT_W-1:0] sat_v;
    sum_v      = {SAT_W{1'b0}};
    sat_v      = {SAT_W{1'b0}};
    out_next_s = {(NumOfNerves*BitSize){1'b0}};
    for (int j = 0; j < NumOfNerves; j++) begin
      sum_v = SAT_W'($signed(ds_h[j])) + SAT_W'($signed(bias[j*BitSize +: BitSize]));
      sat_v = sat_to(sum_v, BitSize);
      out_next_s[j*BitSize +: BitSize] = sat_v[BitSize-1:0];
    end
  end

  // Valid/last pipe and registered output stage.
  always_ff @(posedge clk) begin
    if (res_n) begin
      for (int k = 0; k < LAT - 1; k++) vp_r[k] <= 2'b00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {(NumOfNerves*BitSize){1'b0}};
    end else if (adv_s) begin
      vp_r[0] <= {in_fire_s, in_fire_s && in_last};
      for (int k = 1; k < LAT - 1; k++) vp_r[k] <= vp_r[k-1];
      out_valid_r <= vp_r[LAT-2][1];
      out_last_r  <= vp_r[LAT-2][0];
      out_data_r  <= out_next_s;
    end else begin
      for (int k = 0; k < LAT - 1; k++) vp_r[k] <= vp_r[k];
      out_valid_r <= out_valid_r;
      out_last_r  <= out_last_r;
      out_data_r  <= out_data_r;
    end
  end

  // Array edges with no consumer: rightmost activations and top-row weights.
  always_comb begin
    pe_edge_unused_s = 1'b0;
    for (int i = 0; i < NumOfInputs; i++) begin
      pe_edge_unused_s = pe_edge_unused_s ^ (^a_h[i][NumOfNerves]);
    end
    for (int j = 0; j < NumOfNerves; j++) begin
      pe_edge_unused_s = pe_edge_unused_s ^ (^w_h[0][j]);
    end
  end

  assign w_ready   = w_ready_s;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_systolic_tile_ws.sv
// Directed and randomized bench for systolic_tile_ws (2x2 tile) with an
// arithmetic reference model and a row scoreboard.
module tb_systolic_tile_ws;

  localparam int B  = 8;
  localparam int WB = 4;
  localparam int N  = 2;
  localparam int P  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           res_n, w_valid, w_ready, in_valid, in_ready, in_last;
  logic           out_valid, out_ready, out_last, busy;
  logic [P*WB-1:0] w_data;
  logic [P*B-1:0]  bias, out_data;
  logic [N*B-1:0]  in_data;

  int wm [N][P];
  int n_checks = 0;
  int n_pass   = 0;
  int span_first, span_last;
  logic [N*B-1:0] x_q[$];
  logic [P*B-1:0] exp_q[$];

  systolic_tile_ws #(
    .BitSize(B), .Weight_BitSize(WB), .NumOfInputs(N), .NumOfNerves(P)
  ) dut (
    .clk(clk), .res_n(res_n), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] pack2(input int v0, input int v1);
    logic [31:0] t0, t1;
    t0 = v0;
    t1 = v1;
    return {t1[7:0], t0[7:0]};
  endfunction

  // Y_j = sat(sum_i x_i * W[i][j] + bias_j)
  function automatic logic [P*B-1:0] model(input logic [N*B-1:0] x);
    logic [P*B-1:0] y;
    logic [31:0] t;
    int acc;
    y = '0;
    for (int j = 0; j < P; j++) begin
      acc = $signed(bias[j*B +: B]);
      for (int i = 0; i < N; i++) acc += $signed(x[i*B +: B]) * wm[i][j];
      if (acc > (1 << (B-1)) - 1) acc = (1 << (B-1)) - 1;
      if (acc < -(1 << (B-1)))    acc = -(1 << (B-1));
      t = acc;
      y[j*B +: B] = t[B-1:0];
    end
    return y;
  endfunction

  task automatic load_w(input int a00, input int a01, input int a10, input int a11);
    logic [31:0] t0, t1;
    wm[0][0] = a00; wm[0][1] = a01; wm[1][0] = a10; wm[1][1] = a11;
    for (int k = 0; k < N; k++) begin
      t0 = wm[k][0];
      t1 = wm[k][1];
      w_valid = 1'b1;
      w_data  = {t1[3:0], t0[3:0]};
      #1;
      chk("w_ready_load", w_ready, 1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
  endtask

  task automatic queue_row(input logic [N*B-1:0] x, input logic [P*B-1:0] y);
    x_q.push_back(x);
    exp_q.push_back(y);
  endtask

  task automatic run_stream(input int bubble_pct, input int stall_start,
                            input int stall_len, input bit rand_ready);
    int nrows, sent, got, cyc;
    bit prev_stall;
    logic [P*B-1:0] prev;
    nrows = x_q.size();
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
    while ((got < nrows || busy) && cyc < 400) begin
      @(posedge clk); #1;
      in_valid  = (sent < nrows) && ($urandom_range(99) >= bubble_pct);
      in_data   = (sent < nrows) ? x_q[sent] : '0;
      in_last   = in_valid && (sent == nrows - 1);
      if (cyc >= stall_start && cyc < stall_start + stall_len) out_ready = 1'b0;
      else out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_row", 1, 0);
        else chk("row_data", out_data, exp_q.pop_front());
        chk("row_last", out_last, (got == nrows - 1));
        if (got == 0) span_first = cyc;
        span_last = cyc;
        got++;
      end else if (out_valid) begin
        chk("stall_in_ready", in_ready, 0);
        if (prev_stall) chk("stall_hold", out_data, prev);
      end
      prev_stall = out_valid && !out_ready;
      prev = out_data;
      cyc++;
    end
    chk("stream_done", (got == nrows) && !busy, 1);
    chk("stream_count", exp_q.size(), 0);
    x_q.delete();
    exp_q.delete();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [31:0] t0, t1;
    logic [N*B-1:0] xr;
    res_n = 1'b1; w_valid = 1'b0; w_data = '0; bias = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

    // reset state
    @(posedge clk); #1;
    chk("rst_w_ready", w_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    res_n = 1'b0;

    // basic matrix and latency
    load_w(1, 2, 3, -1);
    chk("loaded_idle", busy, 0);
    in_valid = 1'b1; in_data = pack2(5, 7); in_last = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, N + P);
    chk("basic_data", out_data, pack2(26, 3));
    chk("basic_last", out_last, 1);
    @(posedge clk); #1;
    chk("basic_idle", busy, 0);

    // streaming back-to-back
    queue_row(pack2(1, 0), pack2(1, 2));
    queue_row(pack2(0, 1), pack2(3, -1));
    queue_row(pack2(2, 2), pack2(8, 2));
    run_stream(0, -1, 0, 1'b0);
    chk("stream_span", span_last - span_first, 2);

    // weight reuse, then bias
    queue_row(pack2(5, 7), pack2(26, 3));
    run_stream(0, -1, 0, 1'b0);
    bias = pack2(10, 10);
    queue_row(pack2(5, 7), pack2(36, 13));
    run_stream(0, -1, 0, 1'b0);
    bias = '0;

    // saturation both ways
    load_w(7, 7, 7, 7);
    queue_row(pack2(127, 127), pack2(127, 127));
    run_stream(0, -1, 0, 1'b0);
    load_w(-8, -8, -8, -8);
    queue_row(pack2(127, 127), pack2(-128, -128));
    queue_row(pack2(-128, -128), pack2(127, 127));
    run_stream(0, -1, 0, 1'b0);

    // backpressure with random weights and bias
    load_w(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
           int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
    t0 = $urandom; t1 = $urandom;
    bias = {t1[7:0], t0[7:0]};
    for (int r = 0; r < 8; r++) begin
      xr = 16'($urandom);
      queue_row(xr, model(xr));
    end
    run_stream(0, 6, 5, 1'b0);

    // random bubbles and random out_ready
    for (int r = 0; r < 12; r++) begin
      xr = 16'($urandom);
      queue_row(xr, model(xr));
    end
    run_stream(30, -1, 0, 1'b1);
    bias = '0;

    // weights win over inputs in IDLE
    wm[0][0] = 2; wm[0][1] = -3; wm[1][0] = -1; wm[1][1] = 4;
    w_valid = 1'b1; w_data = pack2(2, -3) & 16'h0f0f;
    w_data = {4'(-3), 4'(2)};
    in_valid = 1'b1; in_data = pack2(3, 5); in_last = 1'b1;
    #1;
    chk("both_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("both_load_busy", busy, 1);
    chk("both_load_in_ready", in_ready, 0);
    w_data = {4'(4), 4'(-1)};
    @(posedge clk); #1;
    w_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("both_loaded_idle", busy, 0);
    queue_row(pack2(3, 5), pack2(1, 11));
    run_stream(0, -1, 0, 1'b0);

    // reset during DRAIN
    in_valid = 1'b1; in_data = pack2(5, 7); in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    chk("drain_busy", busy, 1);
    res_n = 1'b1;
    @(posedge clk); #1;
    res_n = 1'b0;
    chk("drain_rst_out_valid", out_valid, 0);
    chk("drain_rst_busy", busy, 0);
    in_valid = 1'b1; in_data = pack2(1, 1); in_last = 1'b1;
    #1;
    chk("unloaded_in_ready", in_ready, 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("unloaded_no_out", out_valid, 0);
    end
    chk("unloaded_idle", busy, 0);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
